// File: rtl/stride_decoder_if.sv
// Instruction and op-stream bundle between an instruction issuer (master)
// and the stride decoder (slave). Widths match the decoder parameters.

`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 16
`endif
`ifndef KRAM_ADDR_WIDTH
`define KRAM_ADDR_WIDTH 16
`endif

interface stride_decoder_if #(
  parameter int FAW = `FRAM_ADDR_WIDTH,
  parameter int KAW = `KRAM_ADDR_WIDTH,
  parameter int DW  = 32
);
  // Instruction fields
  logic [FAW-1:0] stride_feature_baseaddr;
  logic [KAW-1:0] stride_kernel_baseaddr;
  logic [DW-1:0]  stride_feature_chin;
  logic [DW-1:0]  stride_feature_chout;
  logic [DW-1:0]  stride_feature_width;
  logic [DW-1:0]  stride_feature_height;
  logic [7:0]     stride_kernel_sizeh;
  logic [7:0]     stride_kernel_sizew;
  logic           stride_has_bias;
  logic           stride_has_relu;
  logic [FAW-1:0] stride_wb_baseaddr;
  logic [DW-1:0]  stride_wb_ch_offset;
  logic           inst_valid;
  logic           decoder_ready;

  // Op stream
  logic           op_valid;
  logic           op_ready;
  logic [FAW-1:0] op_fram_addr;
  logic [KAW-1:0] op_kram_addr;
  logic           op_kind;
  logic           op_first;
  logic           op_last;
  logic           op_relu;
  logic [FAW-1:0] op_wb_addr;

  modport master (
    output stride_feature_baseaddr, stride_kernel_baseaddr,
           stride_feature_chin, stride_feature_chout,
           stride_feature_width, stride_feature_height,
           stride_kernel_sizeh, stride_kernel_sizew,
           stride_has_bias, stride_has_relu,
           stride_wb_baseaddr, stride_wb_ch_offset,
           inst_valid, op_ready,
    input  decoder_ready, op_valid, op_fram_addr, op_kram_addr,
           op_kind, op_first, op_last, op_relu, op_wb_addr
  );

  modport slave (
    input  stride_feature_baseaddr, stride_kernel_baseaddr,
           stride_feature_chin, stride_feature_chout,
           stride_feature_width, stride_feature_height,
           stride_kernel_sizeh, stride_kernel_sizew,
           stride_has_bias, stride_has_relu,
           stride_wb_baseaddr, stride_wb_ch_offset,
           inst_valid, op_ready,
    output decoder_ready, op_valid, op_fram_addr, op_kram_addr,
           op_kind, op_first, op_last, op_relu, op_wb_addr
  );
endinterface

// File: rtl/stride_decoder.sv
// Stride decoder: expands one convolution instruction into a stream of
// MAC/BIAS ops, one per output channel x input channel x kernel tap,
// with feature, kernel and writeback addresses for each op.

`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 16
`endif
`ifndef KRAM_ADDR_WIDTH
`define KRAM_ADDR_WIDTH 16
`endif

module stride_decoder #(
  parameter int FAW = `FRAM_ADDR_WIDTH,
  parameter int KAW = `KRAM_ADDR_WIDTH,
  parameter int DW  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  stride_decoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ISSUE} state_t;

  state_t         r_state;

  // Latched instruction
  logic [FAW-1:0] r_fbase;
  logic [KAW-1:0] r_kbase;
  logic [DW-1:0]  r_chin, r_chout, r_width, r_height, r_wb_ch_offset;
  logic [7:0]     r_sizeh, r_sizew;
  logic           r_has_bias, r_has_relu;
  logic [FAW-1:0] r_wb_base;

  // Loop counters describing the op currently presented
  logic [DW-1:0]  r_co, r_ci;
  logic [7:0]     r_kh, r_kw;
  logic           r_bias_phase;

  // Registered op outputs
  logic [FAW-1:0] r_op_fram, r_op_wb;
  logic [KAW-1:0] r_op_kram;
  logic           r_op_kind, r_op_first, r_op_last, r_op_relu;

  // Derived sizes; latched fields are stable for the whole instruction
  logic [DW-1:0]  w_flat, w_ksz, w_kvol;
  logic           w_zero;
  assign w_flat = r_width * r_height;
  assign w_ksz  = DW'(r_sizeh) * DW'(r_sizew);
  assign w_kvol = r_chin * w_ksz;
  assign w_zero = (r_chin == '0) || (r_chout == '0) ||
                  (r_sizeh == '0) || (r_sizew == '0);

  // Candidate counters for the next op to present
  logic [DW-1:0]  w_c_co, w_c_ci;
  logic [7:0]     w_c_kh, w_c_kw;
  logic           w_c_bias, w_done;

  // Next-op counter sequencing: first op in SETUP, otherwise kw->kh->ci->co
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    w_c_bias = 1'b0;
    w_c_co   = r_co;
    w_c_ci   = r_ci;
    w_c_kh   = r_kh;
    w_c_kw   = r_kw;
    w_done   = 1'b0;
    if (r_state == SETUP) begin
      w_c_bias = r_has_bias;
      w_c_co   = '0;
      w_c_ci   = '0;
      w_c_kh   = '0;
      w_c_kw   = '0;
    end else if (r_bias_phase) begin
      w_c_ci = '0;
      w_c_kh = '0;
      w_c_kw = '0;
    end else if (r_kw != r_sizew - 8'd1) begin
      w_c_kw = r_kw + 8'd1;
    end else if (r_kh != r_sizeh - 8'd1) begin
      w_c_kw = '0;
      w_c_kh = r_kh + 8'd1;
    end else if (r_ci != r_chin - DW'(1)) begin
      w_c_kw = '0;
      w_c_kh = '0;
      w_c_ci = r_ci + DW'(1);
    end else begin
      w_c_kw = '0;
      w_c_kh = '0;
      w_c_ci = '0;
      if (r_co == r_chout - DW'(1)) begin
        w_done = 1'b1;
      end else begin
        w_c_co   = r_co + DW'(1);
        w_c_bias = r_has_bias;
      end
    end
  end

  // Address arithmetic for the candidate op (DW-bit products, wrapped sums)
  logic [DW-1:0]  w_mac_foff, w_mac_koff, w_bias_koff, w_wb_off;
  logic [FAW-1:0] w_f_fram, w_f_wb;
  logic [KAW-1:0] w_f_kram;
  logic           w_f_first, w_f_last;
  assign w_mac_foff  = w_c_ci * w_flat + DW'(w_c_kh) * r_width + DW'(w_c_kw);
  assign w_mac_koff  = w_c_co * w_kvol + w_c_ci * w_ksz +
                       DW'(w_c_kh) * DW'(r_sizew) + DW'(w_c_kw);
  assign w_bias_koff = r_chout * w_kvol + w_c_co;
  assign w_wb_off    = w_c_co * r_wb_ch_offset;
  assign w_f_fram    = w_c_bias ? r_fbase : r_fbase + FAW'(w_mac_foff);
  assign w_f_kram    = r_kbase + KAW'(w_c_bias ? w_bias_koff : w_mac_koff);
  assign w_f_wb      = r_wb_base + FAW'(w_wb_off);
  assign w_f_first   = w_c_bias || (!r_has_bias && w_c_ci == '0 &&
                                    w_c_kh == '0 && w_c_kw == '0);
  assign w_f_last    = !w_c_bias && (w_c_ci == r_chin - DW'(1)) &&
                       (w_c_kh == r_sizeh - 8'd1) && (w_c_kw == r_sizew - 8'd1);

  logic w_accept, w_load;
  assign w_accept = (r_state == ISSUE) && bus.op_ready;
  assign w_load   = ((r_state == SETUP) && !w_zero) || (w_accept && !w_done);

  // Control FSM: accept instruction, one setup cycle, issue until last op taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.inst_valid) r_state <= SETUP;
        SETUP:   r_state <= w_zero ? IDLE : ISSUE;
        ISSUE:   if (w_accept && w_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Instruction latch, only while idle so fields never change mid-instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fbase        <= '0;
      r_kbase        <= '0;
      r_chin         <= '0;
      r_chout        <= '0;
      r_width        <= '0;
      r_height       <= '0;
      r_sizeh        <= '0;
      r_sizew        <= '0;
      r_has_bias     <= 1'b0;
      r_has_relu     <= 1'b0;
      r_wb_base      <= '0;
      r_wb_ch_offset <= '0;
    end else if (r_state == IDLE && bus.inst_valid) begin
      r_fbase        <= bus.stride_feature_baseaddr;
      r_kbase        <= bus.stride_kernel_baseaddr;
      r_chin         <= bus.stride_feature_chin;
      r_chout        <= bus.stride_feature_chout;
      r_width        <= bus.stride_feature_width;
      r_height       <= bus.stride_feature_height;
      r_sizeh        <= bus.stride_kernel_sizeh;
      r_sizew        <= bus.stride_kernel_sizew;
      r_has_bias     <= bus.stride_has_bias;
      r_has_relu     <= bus.stride_has_relu;
      r_wb_base      <= bus.stride_wb_baseaddr;
      r_wb_ch_offset <= bus.stride_wb_ch_offset;
    end
  end

  // Counters and op outputs advance together; they hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_co         <= '0;
      r_ci         <= '0;
      r_kh         <= '0;
      r_kw         <= '0;
      r_bias_phase <= 1'b0;
      r_op_fram    <= '0;
      r_op_kram    <= '0;
      r_op_wb      <= '0;
      r_op_kind    <= 1'b0;
      r_op_first   <= 1'b0;
      r_op_last    <= 1'b0;
      r_op_relu    <= 1'b0;
    end else if (w_load) begin
      r_co         <= w_c_co;
      r_ci         <= w_c_ci;
      r_kh         <= w_c_kh;
      r_kw         <= w_c_kw;
      r_bias_phase <= w_c_bias;
      r_op_fram    <= w_f_fram;
      r_op_kram    <= w_f_kram;
      r_op_wb      <= w_f_wb;
      r_op_kind    <= w_c_bias;
      r_op_first   <= w_f_first;
      r_op_last    <= w_f_last;
      r_op_relu    <= r_has_relu;
    end
  end

  assign bus.decoder_ready = (r_state == IDLE);
  assign bus.op_valid      = (r_state == ISSUE);
  assign bus.op_fram_addr  = r_op_fram;
  assign bus.op_kram_addr  = r_op_kram;
  assign bus.op_kind       = r_op_kind;
  assign bus.op_first      = r_op_first;
  assign bus.op_last       = r_op_last;
  assign bus.op_relu       = r_op_relu;
  assign bus.op_wb_addr    = r_op_wb;

endmodule

// File: tb/tb_stride_decoder.sv
// Self-checking bench for stride_decoder: a loop-nest model pushes the
// expected op stream into a queue; accepted ops are popped and compared.

module tb_stride_decoder;

  localparam int FAW = 16;
  localparam int KAW = 16;
  localparam int DW  = 32;

  logic clk;
  logic rst_n;

  stride_decoder_if #(.FAW(FAW), .KAW(KAW), .DW(DW)) bus ();

  stride_decoder #(.FAW(FAW), .KAW(KAW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] fram;
    logic [15:0] kram;
    logic [15:0] wb;
    logic        kind;
    logic        first;
    logic        last;
    logic        relu;
  } op_t;

  typedef struct {
    int fb, kb, w, h, chin, chout, sh, sw;
    bit bias, relu;
    int wbb, wbo;
  } cfg_t;

  op_t exp_q[$];
  op_t got_q[$];
  int  checks = 0;
  int  errors = 0;
  int  first_acc_cyc, last_acc_cyc;

  function automatic string fmt(input op_t o);
    return $sformatf("fram=%0d kram=%0d wb=%0d kind=%0b first=%0b last=%0b relu=%0b",
                     o.fram, o.kram, o.wb, o.kind, o.first, o.last, o.relu);
  endfunction

  function automatic op_t sample_op();
    op_t o;
    o.fram  = bus.op_fram_addr;
    o.kram  = bus.op_kram_addr;
    o.wb    = bus.op_wb_addr;
    o.kind  = bus.op_kind;
    o.first = bus.op_first;
    o.last  = bus.op_last;
    o.relu  = bus.op_relu;
    return o;
  endfunction

  // Reference loop nest: bias first per channel, then ci/kh/kw with kw innermost
  task automatic model(input cfg_t c);
    int flat, ksz, kvol;
    op_t o;
    if (c.chin == 0 || c.chout == 0 || c.sh == 0 || c.sw == 0) return;
    flat = c.w * c.h;
    ksz  = c.sh * c.sw;
    kvol = c.chin * ksz;
    for (int co = 0; co < c.chout; co++) begin
      if (c.bias) begin
        o.fram = 16'(c.fb);
        o.kram = 16'(c.kb + c.chout * kvol + co);
        o.wb = 16'(c.wbb + co * c.wbo);
        o.kind = 1'b1; o.first = 1'b1; o.last = 1'b0; o.relu = c.relu;
        exp_q.push_back(o);
      end
      for (int ci = 0; ci < c.chin; ci++)
        for (int kh = 0; kh < c.sh; kh++)
          for (int kw = 0; kw < c.sw; kw++) begin
            o.fram  = 16'(c.fb + ci * flat + kh * c.w + kw);
            o.kram  = 16'(c.kb + co * kvol + ci * ksz + kh * c.sw + kw);
            o.wb    = 16'(c.wbb + co * c.wbo);
            o.kind  = 1'b0;
            o.first = !c.bias && ci == 0 && kh == 0 && kw == 0;
            o.last  = ci == c.chin - 1 && kh == c.sh - 1 && kw == c.sw - 1;
            o.relu  = c.relu;
            exp_q.push_back(o);
          end
    end
  endtask

  task automatic set_fields(input cfg_t c);
    bus.stride_feature_baseaddr = 16'(c.fb);
    bus.stride_kernel_baseaddr  = 16'(c.kb);
    bus.stride_feature_chin     = 32'(c.chin);
    bus.stride_feature_chout    = 32'(c.chout);
    bus.stride_feature_width    = 32'(c.w);
    bus.stride_feature_height   = 32'(c.h);
    bus.stride_kernel_sizeh     = 8'(c.sh);
    bus.stride_kernel_sizew     = 8'(c.sw);
    bus.stride_has_bias         = c.bias;
    bus.stride_has_relu         = c.relu;
    bus.stride_wb_baseaddr      = 16'(c.wbb);
    bus.stride_wb_ch_offset     = 32'(c.wbo);
  endtask

  // Present an instruction; returns #1 after the acceptance edge
  task automatic drive_inst(input cfg_t c);
    int n = 0;
    @(negedge clk);
    set_fields(c);
    bus.inst_valid = 1'b1;
    while (!bus.decoder_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.decoder_ready) begin
      errors++;
      $display("FAIL accept_timeout: decoder_ready=%0b, required 1 within 100 cycles", bus.decoder_ready);
    end
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
  endtask

  // Consume n ops, comparing each against the scoreboard; checks stall stability
  task automatic run_ops(input int n, input bit rand_ready, input int budget, input string tag);
    op_t cur, held, ex;
    bit  held_v = 1'b0;
    int  got = 0;
    int  cyc = 0;
    got_q.delete();
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (held_v) begin
        cur = sample_op();
        checks++;
        if (!bus.op_valid || cur !== held) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%0b %s, required valid=1 %s",
                   tag, bus.op_valid, fmt(cur), fmt(held));
        end
      end
      bus.op_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      held_v = 1'b0;
      if (bus.op_valid) begin
        cur = sample_op();
        if (bus.op_ready) begin
          if (got == 0) first_acc_cyc = cyc;
          last_acc_cyc = cyc;
          got_q.push_back(cur);
          got++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s op%0d unexpected: %s, required no op", tag, got - 1, fmt(cur));
          end else begin
            ex = exp_q.pop_front();
            if (cur !== ex) begin
              errors++;
              $display("FAIL %s op%0d: %s, required %s", tag, got - 1, fmt(cur), fmt(ex));
            end
          end
        end else begin
          held   = cur;
          held_v = 1'b1;
        end
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s op_count: got %0d ops, required %0d", tag, got, n);
    end
  endtask

  // After the final op is accepted: no more ops, decoder ready again
  task automatic check_done(input string tag);
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b0 || bus.decoder_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s done: op_valid=%0b decoder_ready=%0b, required 0/1",
               tag, bus.op_valid, bus.decoder_ready);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (bus.op_valid !== 1'b0 || bus.op_fram_addr !== '0 || bus.op_kram_addr !== '0 ||
        bus.op_wb_addr !== '0 || bus.op_kind !== 1'b0 || bus.op_first !== 1'b0 ||
        bus.op_last !== 1'b0 || bus.op_relu !== 1'b0 || bus.decoder_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s reset_outputs: valid=%0b ready=%0b %s, required all op outputs 0 and ready 1",
               tag, bus.op_valid, bus.decoder_ready, fmt(sample_op()));
    end
  endtask

  function automatic cfg_t cfg_3x3();
    cfg_t c;
    c.fb = 10; c.kb = 0; c.w = 5; c.h = 5; c.chin = 2; c.chout = 1;
    c.sh = 3; c.sw = 3; c.bias = 0; c.relu = 0; c.wbb = 0; c.wbo = 0;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_release");
  endtask

  task automatic test_single();
    cfg_t c;
    c.fb = 7; c.kb = 3; c.w = 4; c.h = 4; c.chin = 1; c.chout = 1;
    c.sh = 1; c.sw = 1; c.bias = 0; c.relu = 0; c.wbb = 0; c.wbo = 0;
    model(c);
    drive_inst(c);
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b0 || bus.decoder_ready !== 1'b0) begin
      errors++;
      $display("FAIL single setup_cycle: op_valid=%0b decoder_ready=%0b, required 0/0",
               bus.op_valid, bus.decoder_ready);
    end
    run_ops(1, 1'b0, 10, "single");
    if (got_q.size() == 1) begin
      checks++;
      if (got_q[0].fram !== 16'd7 || got_q[0].kram !== 16'd3 ||
          got_q[0].first !== 1'b1 || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL single op0: %s, required fram=7 kram=3 first=1 last=1", fmt(got_q[0]));
      end
    end
    check_done("single");
  endtask

  task automatic test_3x3();
    cfg_t c = cfg_3x3();
    model(c);
    drive_inst(c);
    run_ops(18, 1'b0, 100, "k3x3");
    if (got_q.size() == 18) begin
      checks++;
      if (got_q[9].fram !== 16'd35 || got_q[9].kram !== 16'd9 || got_q[9].first !== 1'b0) begin
        errors++;
        $display("FAIL k3x3 op9: %s, required fram=35 kram=9 first=0", fmt(got_q[9]));
      end
      checks++;
      if (got_q[17].fram !== 16'd47 || got_q[17].kram !== 16'd17 || got_q[17].last !== 1'b1) begin
        errors++;
        $display("FAIL k3x3 op17: %s, required fram=47 kram=17 last=1", fmt(got_q[17]));
      end
    end
    checks++;
    if (last_acc_cyc - first_acc_cyc + 1 != 18) begin
      errors++;
      $display("FAIL k3x3 back_to_back: 18 ops took %0d cycles, required 18",
               last_acc_cyc - first_acc_cyc + 1);
    end
    check_done("k3x3");
  endtask

  task automatic test_bias();
    cfg_t c = cfg_3x3();
    c.bias = 1; c.chout = 2; c.relu = 1; c.wbb = 100; c.wbo = 9;
    model(c);
    drive_inst(c);
    run_ops(38, 1'b0, 200, "bias");
    if (got_q.size() == 38) begin
      checks++;
      if (got_q[0].kind !== 1'b1 || got_q[0].kram !== 16'd36 || got_q[0].wb !== 16'd100) begin
        errors++;
        $display("FAIL bias op0: %s, required kind=1 kram=36 wb=100", fmt(got_q[0]));
      end
      checks++;
      if (got_q[19].kind !== 1'b1 || got_q[19].kram !== 16'd37 ||
          got_q[19].first !== 1'b1 || got_q[19].wb !== 16'd109) begin
        errors++;
        $display("FAIL bias op19: %s, required kind=1 kram=37 first=1 wb=109", fmt(got_q[19]));
      end
    end
    checks++;
    if (last_acc_cyc - first_acc_cyc + 1 != 38) begin
      errors++;
      $display("FAIL bias back_to_back: 38 ops took %0d cycles, required 38",
               last_acc_cyc - first_acc_cyc + 1);
    end
    check_done("bias");
  endtask

  task automatic test_stall();
    cfg_t c = cfg_3x3();
    model(c);
    drive_inst(c);
    run_ops(18, 1'b1, 1000, "stall");
    bus.op_ready = 1'b1;
    check_done("stall");
  endtask

  task automatic test_zero();
    cfg_t c;
    for (int v = 0; v < 3; v++) begin
      c = cfg_3x3();
      if (v == 0) c.chin = 0;
      if (v == 1) c.chout = 0;
      if (v == 2) begin c.sw = 0; c.bias = 1; end
      model(c);
      drive_inst(c);
      @(negedge clk);
      checks++;
      if (bus.op_valid !== 1'b0 || bus.decoder_ready !== 1'b0) begin
        errors++;
        $display("FAIL zero%0d setup: op_valid=%0b decoder_ready=%0b, required 0/0",
                 v, bus.op_valid, bus.decoder_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.op_valid !== 1'b0 || bus.decoder_ready !== 1'b1) begin
        errors++;
        $display("FAIL zero%0d idle: op_valid=%0b decoder_ready=%0b, required 0/1",
                 v, bus.op_valid, bus.decoder_ready);
      end
    end
  endtask

  task automatic test_hold_inst();
    cfg_t a = cfg_3x3();
    cfg_t b;
    b.fb = 500; b.kb = 44; b.w = 3; b.h = 3; b.chin = 1; b.chout = 1;
    b.sh = 1; b.sw = 1; b.bias = 0; b.relu = 1; b.wbb = 20; b.wbo = 0;
    model(a);
    drive_inst(a);
    set_fields(b);
    bus.inst_valid = 1'b1;
    run_ops(18, 1'b0, 100, "hold_a");
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b0 || bus.decoder_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold idle_gap: op_valid=%0b decoder_ready=%0b, required 0/1",
               bus.op_valid, bus.decoder_ready);
    end
    @(posedge clk);
    #1;
    bus.inst_valid = 1'b0;
    checks++;
    if (bus.decoder_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold accept_b: decoder_ready=%0b, required 0", bus.decoder_ready);
    end
    model(b);
    run_ops(1, 1'b0, 10, "hold_b");
    check_done("hold_b");
  endtask

  task automatic test_reset_mid();
    cfg_t c = cfg_3x3();
    model(c);
    drive_inst(c);
    run_ops(5, 1'b0, 50, "rstmid");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rstmid_async");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.op_valid !== 1'b0 || bus.decoder_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid after_release%0d: op_valid=%0b decoder_ready=%0b, required 0/1",
                 i, bus.op_valid, bus.decoder_ready);
      end
    end
  endtask

  initial begin
    bus.inst_valid = 1'b0;
    bus.op_ready   = 1'b1;
    set_fields(cfg_3x3());
    test_reset();
    test_single();
    test_3x3();
    test_bias();
    test_stall();
    test_zero();
    test_hold_inst();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: %0d ops never produced, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stride_decoder.md
STRIDE_DECODER -- requirements
Module: stride_decoder

Interface
REQ-001 SHALL take parameters: FAW, default `FRAM_ADDR_WIDTH, feature/writeback RAM word-address width; KAW, default `KRAM_ADDR_WIDTH, kernel RAM word-address width; DW, default 32, width of `DATA_RANGE fields.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: stride_feature_baseaddr  in  FAW  window top-left word address, channel 0; stride_kernel_baseaddr  in  KAW  kernel block base.
REQ-004 SHALL have ports: stride_feature_chin, stride_feature_chout, stride_feature_width, stride_feature_height  in  DW each; stride_kernel_sizeh, stride_kernel_sizew  in  8 each.
REQ-005 SHALL have ports: stride_has_bias, stride_has_relu  in  1 each; stride_wb_baseaddr  in  FAW; stride_wb_ch_offset  in  DW  output-channel plane size.
REQ-006 SHALL have ports: inst_valid  in  1; decoder_ready  out  1  instruction accepted when both high at posedge.
REQ-007 SHALL have ports: op_valid  out  1; op_ready  in  1; op_fram_addr  out  FAW; op_kram_addr  out  KAW; op_kind  out  1 (0 MAC, 1 BIAS); op_first, op_last, op_relu  out  1 each; op_wb_addr  out  FAW.

Function
REQ-008 SHALL implement states IDLE, SETUP, ISSUE; decoder_ready = (state==IDLE); op_valid = (state==ISSUE).
REQ-009 IDLE->SETUP on inst_valid&&decoder_ready, latching all stride_* inputs; otherwise stay IDLE.
REQ-010 SETUP lasts exactly one cycle: computes flat = width*height, ksz = sizeh*sizew, kvol = chin*ksz; clears counters co, ci, kh, kw and bias-phase flag; first op_valid appears the cycle after SETUP (2 cycles after acceptance edge).
REQ-011 If latched chin, chout, sizeh or sizew is zero, SETUP SHALL go to IDLE, issuing no ops.
REQ-012 Per output channel co (0..chout-1): if has_bias, one BIAS op first; then MAC ops with kw innermost, then kh, then ci.
REQ-013 Total ops per instruction SHALL be chout*(kvol + has_bias).
REQ-014 MAC op: op_fram_addr = fbase + ci*flat + kh*width + kw; op_kram_addr = kbase + co*kvol + ci*ksz + kh*sizew + kw.
REQ-015 BIAS op: op_kram_addr = kbase + chout*kvol + co; op_fram_addr = fbase.
REQ-016 All address sums SHALL wrap modulo 2^FAW / 2^KAW; products are DW-bit, truncated.
REQ-017 op_first = 1 on first op of each channel (BIAS if present, else MAC ci=kh=kw=0).
REQ-018 op_last = 1 on MAC with ci=chin-1, kh=sizeh-1, kw=sizew-1; a BIAS op never has op_last.
REQ-019 op_wb_addr = wb_base + co*wb_ch_offset and op_relu = latched has_relu on every op.
REQ-020 Counters advance only on op_valid&&op_ready; all op_* outputs SHALL hold stable while op_valid&&!op_ready.
REQ-021 Acceptance of the last op of the last channel SHALL move ISSUE->IDLE; decoder_ready is high the next cycle; no further op_valid.
REQ-022 inst_valid is ignored outside IDLE; latched fields do not change mid-instruction.
REQ-023 With op_ready held high, one op SHALL be accepted per cycle without bubbles, including across kw/kh/ci/co and bias boundaries.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, all counters and latched fields 0, op_valid 0, all op_* outputs 0, decoder_ready 1 after reset release.
REQ-025 Reset asserted mid-instruction SHALL abandon it; no op emitted after release until a new instruction is accepted.

Verification
REQ-026 1x1 kernel, chin=1, chout=1, no bias, fbase=7, kbase=3, op_ready=1 -> single op: fram 7, kram 3, first=last=1, decoder_ready high 1 cycle after acceptance.
REQ-027 3x3, width=height=5, chin=2, chout=1, fbase=10, kbase=0, no bias -> 18 ops; op#9 fram 35 kram 9 first=0; op#17 fram 47 kram 17 last=1.
REQ-028 Same with has_bias=1, chout=2, wb_base=100, wb_ch_offset=9 -> 38 ops; op#19 BIAS, kram 37, first=1, wb_addr 109; op#0 BIAS kram 36 wb_addr 100.
REQ-029 op_ready toggled pseudo-randomly -> identical op sequence to REQ-027, outputs stable during stalls, no duplicated or dropped op.
REQ-030 chin=0 -> zero ops, IDLE 2 cycles after acceptance; inst_valid held during ISSUE -> not accepted until IDLE.
REQ-031 rst_n pulsed low after 5 ops of REQ-027 -> op_valid 0 immediately, all outputs 0, decoder_ready 1 after release.
